// File: rtl/ntt_defines_pkg.sv
// Shared NTT definitions: butterfly mode tag, default modulus and lane-count helper.
`timescale 1ns/1ps
package ntt_defines_pkg;

   typedef enum logic {
      BF_CT = 1'b0,
      BF_GS = 1'b1
   } bf_mode_e;

   localparam int          DEFAULT_REG_SIZE = 23;
   localparam logic [22:0] DEFAULT_Q        = 23'd8380417;

   function automatic int lane_count(input int stages);
      return 32'sd1 << stages;
   endfunction

endpackage

// File: rtl/ntt_bf_unit.sv
// Single radix-2 butterfly, CT or GS per entry, fixed BF_LATENCY with a shared stall enable.
`timescale 1ns/1ps
module ntt_bf_unit
   import ntt_defines_pkg::*;
#(
   parameter int                  REG_SIZE   = DEFAULT_REG_SIZE,
   parameter logic [REG_SIZE-1:0] Q          = REG_SIZE'(DEFAULT_Q),
   parameter int                  BF_LATENCY = 5
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                clr_i,
   input  logic                en_i,
   input  bf_mode_e            mode_i,
   input  logic [REG_SIZE-1:0] u_i,
   input  logic [REG_SIZE-1:0] v_i,
   input  logic [REG_SIZE-1:0] w_i,
   output logic [REG_SIZE-1:0] u_o,
   output logic [REG_SIZE-1:0] v_o
);

   localparam int DLY = BF_LATENCY - 1;

   typedef logic [REG_SIZE-1:0] coef_t;

   function automatic coef_t add_mod(input coef_t a, input coef_t b);
      logic [REG_SIZE:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, Q}) s = s - {1'b0, Q};
      return s[REG_SIZE-1:0];
   endfunction

   function automatic coef_t sub_mod(input coef_t a, input coef_t b);
      logic [REG_SIZE:0] d;
      if (a >= b) d = {1'b0, a} - {1'b0, b};
      else        d = {1'b0, a} + {1'b0, Q} - {1'b0, b};
      return d[REG_SIZE-1:0];
   endfunction

   function automatic coef_t mul_mod(input coef_t a, input coef_t b);
      logic [2*REG_SIZE-1:0] p;
      p = {{REG_SIZE{1'b0}}, a} * {{REG_SIZE{1'b0}}, b};
      return coef_t'(p % {{REG_SIZE{1'b0}}, Q});
   endfunction

   bf_mode_e mode_p0_q;
   coef_t    u_p0_q, v_p0_q, w_p0_q;
   coef_t    gs_diff, mul_a, prod;
   coef_t    u_p1_d, v_p1_d;
   logic [DLY-1:0][REG_SIZE-1:0] u_dly_q, v_dly_q;

   // p0: operand capture
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mode_p0_q <= BF_CT;
         u_p0_q    <= '0;
         v_p0_q    <= '0;
         w_p0_q    <= '0;
      end else if (clr_i) begin
         mode_p0_q <= BF_CT;
         u_p0_q    <= '0;
         v_p0_q    <= '0;
         w_p0_q    <= '0;
      end else if (en_i) begin
         mode_p0_q <= mode_i;
         u_p0_q    <= u_i;
         v_p0_q    <= v_i;
         w_p0_q    <= w_i;
      end
   end

   // p1: one shared multiplier; CT multiplies v, GS multiplies (u - v)
   always_comb begin
      gs_diff = sub_mod(u_p0_q, v_p0_q);
      mul_a   = (mode_p0_q == BF_CT) ? v_p0_q : gs_diff;
      prod    = mul_mod(mul_a, w_p0_q);
      u_p1_d  = '0;
      v_p1_d  = '0;
      if (mode_p0_q == BF_CT) begin
         u_p1_d = add_mod(u_p0_q, prod);
         v_p1_d = sub_mod(u_p0_q, prod);
      end else begin
         u_p1_d = add_mod(u_p0_q, v_p0_q);
         v_p1_d = prod;
      end
   end

   // p1 .. p(BF_LATENCY-1): result register followed by latency padding
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         u_dly_q <= '0;
         v_dly_q <= '0;
      end else if (clr_i) begin
         u_dly_q <= '0;
         v_dly_q <= '0;
      end else if (en_i) begin
         u_dly_q[0] <= u_p1_d;
         v_dly_q[0] <= v_p1_d;
         for (int k = 1; k < DLY; k++) begin
            u_dly_q[k] <= u_dly_q[k-1];
            v_dly_q[k] <= v_dly_q[k-1];
         end
      end
   end

   assign u_o = u_dly_q[DLY-1];
   assign v_o = v_dly_q[DLY-1];

endmodule

// File: rtl/ntt_bf_network.sv
// NUM_STAGES radix-2 butterfly stages over 2^NUM_STAGES lanes with perfect-shuffle wiring,
// per-vector CT/GS tag and a single global advance for valid/ready backpressure.
`timescale 1ns/1ps
module ntt_bf_network
   import ntt_defines_pkg::*;
#(
   parameter int                  REG_SIZE   = DEFAULT_REG_SIZE,
   parameter logic [REG_SIZE-1:0] Q          = REG_SIZE'(DEFAULT_Q),
   parameter int                  NUM_STAGES = 2,
   parameter int                  BF_LATENCY = 5
) (
   input  logic                                                 clk,
   input  logic                                                 reset_n,
   input  logic                                                 zeroize,
   input  logic                                                 in_valid,
   output logic                                                 in_ready,
   input  logic                                                 in_mode,
   input  logic [lane_count(NUM_STAGES)*REG_SIZE-1:0]           in_data,
   input  logic [NUM_STAGES*(lane_count(NUM_STAGES)/2)*REG_SIZE-1:0] in_twiddle,
   output logic                                                 out_valid,
   input  logic                                                 out_ready,
   output logic [lane_count(NUM_STAGES)*REG_SIZE-1:0]           out_data,
   output logic                                                 out_mode,
   output logic                                                 busy
);

   localparam int N     = lane_count(NUM_STAGES);
   localparam int HALF  = N / 2;
   localparam int DEPTH = NUM_STAGES * BF_LATENCY;
   localparam int NW    = N * REG_SIZE;
   localparam int TW    = HALF * REG_SIZE;

   logic                 adv;
   logic [DEPTH-1:0]     vld_q, vld_d;
   logic [DEPTH-1:0]     mode_q, mode_d;
   logic                 out_valid_q, out_mode_q;
   logic [NW-1:0]        out_data_q;

   logic [NUM_STAGES:0][N-1:0][REG_SIZE-1:0]      lane_w;
   logic [NUM_STAGES-1:0][HALF-1:0][REG_SIZE-1:0] stage_tw;
   logic [NUM_STAGES-1:0]                         stage_mode;

   // Everything moves together or not at all, so the output register never overflows.
   assign adv      = !out_valid_q || out_ready;
   assign in_ready = adv;

   assign vld_d  = {vld_q[DEPTH-2:0], in_valid};
   assign mode_d = {mode_q[DEPTH-2:0], in_mode};

   assign lane_w[0] = in_data;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_q       <= '0;
         mode_q      <= '0;
         out_valid_q <= 1'b0;
         out_mode_q  <= 1'b0;
         out_data_q  <= '0;
      end else if (zeroize) begin
         vld_q       <= '0;
         mode_q      <= '0;
         out_valid_q <= 1'b0;
         out_mode_q  <= 1'b0;
         out_data_q  <= '0;
      end else if (adv) begin
         vld_q       <= vld_d;
         mode_q      <= mode_d;
         out_valid_q <= vld_q[DEPTH-1];
         out_mode_q  <= mode_q[DEPTH-1];
         out_data_q  <= lane_w[NUM_STAGES];
      end
   end

   for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
      if (s == 0) begin : g_head
         assign stage_tw[s]   = in_twiddle[TW-1:0];
         assign stage_mode[s] = in_mode;
      end else begin : g_tail
         // Twiddles ride s*BF_LATENCY advancing cycles so they meet their vector at stage s.
         localparam int TD = s * BF_LATENCY;
         logic [TD-1:0][TW-1:0] twd_q;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               twd_q <= '0;
            end else if (zeroize) begin
               twd_q <= '0;
            end else if (adv) begin
               twd_q <= {twd_q[TD-2:0], in_twiddle[s*TW +: TW]};
            end
         end

         assign stage_tw[s]   = twd_q[TD-1];
         assign stage_mode[s] = mode_q[TD-1];
      end

      for (genvar j = 0; j < HALF; j++) begin : g_bf
         ntt_bf_unit #(
            .REG_SIZE   (REG_SIZE),
            .Q          (Q),
            .BF_LATENCY (BF_LATENCY)
         ) u_bf (
            .clk     (clk),
            .reset_n (reset_n),
            .clr_i   (zeroize),
            .en_i    (adv),
            .mode_i  (bf_mode_e'(stage_mode[s])),
            .u_i     (lane_w[s][2*j]),
            .v_i     (lane_w[s][2*j+1]),
            .w_i     (stage_tw[s][j]),
            .u_o     (lane_w[s+1][j]),
            .v_o     (lane_w[s+1][j+HALF])
         );
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_mode  = out_mode_q;
   assign busy      = (|vld_q) || out_valid_q;

   function automatic logic inputs_in_range(input logic [NW-1:0]            d,
                                            input logic [NUM_STAGES*TW-1:0] tw);
      logic ok;
      ok = 1'b1;
      for (int k = 0; k < N; k++)
         if (d[k*REG_SIZE +: REG_SIZE] >= Q) ok = 1'b0;
      for (int k = 0; k < NUM_STAGES*HALF; k++)
         if (tw[k*REG_SIZE +: REG_SIZE] >= Q) ok = 1'b0;
      return ok;
   endfunction

   a_in_range: assert property (@(posedge clk) disable iff (!reset_n)
      (in_valid && adv && !zeroize) |-> inputs_in_range(in_data, in_twiddle));

endmodule

// File: tb/tb_ntt_bf_network.sv
// Scoreboard bench: a 2-stage network under directed, random-backpressure and zeroize traffic,
// plus a 1-stage instance for single-butterfly vectors.
`timescale 1ns/1ps
module tb_ntt_bf_network;

   localparam int     R   = 23;
   localparam int     QI  = 8380417;
   localparam longint QL  = 64'd8380417;
   localparam int     LAT  = 10;
   localparam int     LAT1 = 5;

   logic        clk, reset_n, zeroize;
   logic        in_valid, in_ready, in_mode, out_valid, out_ready, out_mode, busy;
   logic [91:0] in_data, in_twiddle, out_data;

   logic        in_valid1, in_ready1, in_mode1, out_valid1, out_mode1, busy1;
   logic        out_ready1;
   logic [45:0] in_data1, out_data1;
   logic [22:0] in_tw1;

   typedef struct {
      logic [91:0] data;
      logic        mode;
      int          due;
   } exp_t;

   exp_t exp_q[$];
   exp_t exp1_q[$];

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   logic rnd_bp = 1'b0;

   logic [91:0] held_data;
   logic        held_mode;
   logic        stalled = 1'b0;

   ntt_bf_network #(.REG_SIZE(23), .Q(23'd8380417), .NUM_STAGES(2), .BF_LATENCY(5)) dut (
      .clk(clk), .reset_n(reset_n), .zeroize(zeroize),
      .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
      .in_data(in_data), .in_twiddle(in_twiddle),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_mode(out_mode), .busy(busy));

   ntt_bf_network #(.REG_SIZE(23), .Q(23'd8380417), .NUM_STAGES(1), .BF_LATENCY(5)) dut1 (
      .clk(clk), .reset_n(reset_n), .zeroize(zeroize),
      .in_valid(in_valid1), .in_ready(in_ready1), .in_mode(in_mode1),
      .in_data(in_data1), .in_twiddle(in_tw1),
      .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
      .out_mode(out_mode1), .busy(busy1));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [91:0] act, input logic [91:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   // Spec-level reference: radix-2 stages with perfect shuffle, plain integer arithmetic.
   function automatic logic [91:0] model(input logic [91:0] d, input logic [91:0] tw, input logic m);
      longint a[4], b[4];
      longint u, v, w, t;
      logic [91:0] r;
      for (int k = 0; k < 4; k++) a[k] = longint'(d[k*R +: R]);
      for (int s = 0; s < 2; s++) begin
         for (int j = 0; j < 2; j++) begin
            u = a[2*j];
            v = a[2*j+1];
            w = longint'(tw[(s*2+j)*R +: R]);
            if (m == 1'b0) begin
               t      = (v * w) % QL;
               b[j]   = (u + t) % QL;
               b[j+2] = (u - t + QL) % QL;
            end else begin
               b[j]   = (u + v) % QL;
               b[j+2] = (((u - v + QL) % QL) * w) % QL;
            end
         end
         a = b;
      end
      r = '0;
      for (int k = 0; k < 4; k++) r[k*R +: R] = 23'(a[k]);
      return r;
   endfunction

   // Backpressure driver: random 50% when enabled, otherwise always ready.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = rnd_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   always @(negedge clk) begin
      if (!reset_n || zeroize) begin
         stalled <= 1'b0;
      end else begin
         if (stalled && out_valid) begin
            check("stall_data", out_data, held_data);
            check("stall_mode", 92'(out_mode), 92'(held_mode));
         end
         stalled   <= out_valid && !out_ready;
         held_data <= out_data;
         held_mode <= out_mode;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL net_unexpected: got out_valid=1 data %0h, want no output", out_data);
            end else begin
               check("net_data", out_data, exp_q[0].data);
               check("net_mode", 92'(out_mode), 92'(exp_q[0].mode));
               if (exp_q[0].due >= 0) check("net_latency", 92'(cyc), 92'(exp_q[0].due));
               void'(exp_q.pop_front());
            end
         end
      end
   end

   always @(negedge clk) begin
      if (reset_n && !zeroize && out_valid1) begin
         if (exp1_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL bf1_unexpected: got out_valid=1 data %0h, want no output", out_data1);
         end else begin
            check("bf1_data", 92'(out_data1), exp1_q[0].data);
            check("bf1_mode", 92'(out_mode1), 92'(exp1_q[0].mode));
            check("bf1_latency", 92'(cyc), 92'(exp1_q[0].due));
            void'(exp1_q.pop_front());
         end
      end
   end

   task automatic send(input logic [91:0] d, input logic [91:0] tw, input logic m,
                       input logic [91:0] expv, input bit timed);
      int waited = 0;
      bit done   = 0;
      in_valid   = 1'b1;
      in_data    = d;
      in_twiddle = tw;
      in_mode    = m;
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back('{data: expv, mode: m, due: (timed ? cyc + 1 + LAT : -1)});
            done = 1;
         end
         @(posedge clk);
         #1;
         if (!done) begin
            waited++;
            if (waited > 200) begin
               total++;
               bad++;
               $display("FAIL send_timeout: in_ready stuck at 0 for %0d cycles", waited);
               done = 1;
            end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic send1(input logic [45:0] d, input logic [22:0] w, input logic m, input logic [45:0] expv);
      in_valid1 = 1'b1;
      in_data1  = d;
      in_tw1    = w;
      in_mode1  = m;
      @(negedge clk);
      if (in_ready1) begin
         exp1_q.push_back('{data: 92'(expv), mode: m, due: cyc + 1 + LAT1});
      end else begin
         total++;
         bad++;
         $display("FAIL bf1_in_ready: got 0 want 1");
      end
      @(posedge clk);
      #1;
      in_valid1 = 1'b0;
   endtask

   task automatic drain(input int limit);
      int n = 0;
      while ((exp_q.size() > 0 || exp1_q.size() > 0) && n < limit) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (exp_q.size() > 0 || exp1_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: %0d vectors still pending, want 0", exp_q.size() + exp1_q.size());
         exp_q.delete();
         exp1_q.delete();
      end
   endtask

   function automatic logic [22:0] rnd_coef();
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) return 23'd0;
      if (r == 1) return 23'(QI - 1);
      return 23'($urandom_range(0, QI - 1));
   endfunction

   initial begin
      logic [91:0] d, tw;
      logic        m;

      reset_n    = 1'b0;
      zeroize    = 1'b0;
      in_valid   = 1'b0;
      in_mode    = 1'b0;
      in_data    = '0;
      in_twiddle = '0;
      in_valid1  = 1'b0;
      in_mode1   = 1'b0;
      in_data1   = '0;
      in_tw1     = '0;
      out_ready1 = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 92'(out_valid), 92'(1'b0));
      check("rst_out_data",  out_data, '0);
      check("rst_out_mode",  92'(out_mode), 92'(1'b0));
      check("rst_busy",      92'(busy), 92'(1'b0));
      check("rst_in_ready",  92'(in_ready), 92'(1'b1));
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Single butterfly: lane 0 = u, lane 1 = v.
      send1({23'd2, 23'd1}, 23'd3, 1'b0, {23'd8380412, 23'd7});
      send1({23'd3, 23'd5}, 23'd4, 1'b1, {23'd8, 23'd8});
      send1({23'd1, 23'd8380416}, 23'd1, 1'b0, {23'd8380415, 23'd0});
      send1({23'd1, 23'd0}, 23'd1, 1'b1, {23'd8380416, 23'd1});
      drain(100);

      // Two stages, back-to-back with mixed modes, hand-computed results.
      send({4{23'd1}}, {4{23'd1}}, 1'b0, {23'd0, 23'd0, 23'd0, 23'd4}, 1);
      send({4{23'd1}}, {4{23'd1}}, 1'b1, {23'd0, 23'd0, 23'd0, 23'd4}, 1);
      send({23'd4, 23'd3, 23'd2, 23'd1}, {4{23'd1}}, 1'b1,
           {23'd0, 23'd8380413, 23'd8380415, 23'd10}, 1);
      send({23'd4, 23'd3, 23'd2, 23'd1}, {23'd1, 23'd1, 23'd5, 23'd3}, 1'b0,
           {23'd12, 23'd8380401, 23'd8380395, 23'd30}, 1);
      send({4{23'd8380416}}, {4{23'd1}}, 1'b0, {23'd0, 23'd0, 23'd0, 23'd8380413}, 1);
      drain(100);

      // Random vectors under 50% backpressure with occasional input bubbles.
      rnd_bp = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         for (int k = 0; k < 4; k++) begin
            d[k*R +: R]  = rnd_coef();
            tw[k*R +: R] = rnd_coef();
         end
         m = 1'($urandom_range(0, 1));
         send(d, tw, m, model(d, tw, m), 0);
         if ($urandom_range(0, 7) == 0) begin
            @(posedge clk);
            #1;
         end
      end
      rnd_bp = 1'b0;
      drain(5000);

      // Zeroize with six vectors in flight.
      for (int i = 0; i < 6; i++)
         send({4{23'(i + 1)}}, {4{23'd2}}, 1'(i % 2), '0, 0);
      check("zq_busy_before", 92'(busy), 92'(1'b1));
      zeroize = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      zeroize = 1'b0;
      check("zq_out_valid", 92'(out_valid), 92'(1'b0));
      check("zq_busy",      92'(busy), 92'(1'b0));
      check("zq_in_ready",  92'(in_ready), 92'(1'b1));
      repeat (30) @(posedge clk);
      #1;
      send({4{23'd1}}, {4{23'd1}}, 1'b0, {23'd0, 23'd0, 23'd0, 23'd4}, 1);
      drain(100);

      // Asynchronous reset mid-flight clears state without a clock edge.
      for (int i = 0; i < 3; i++)
         send({4{23'd7}}, {4{23'd3}}, 1'b1, '0, 0);
      #2;
      reset_n = 1'b0;
      exp_q.delete();
      #1;
      check("arst_busy",      92'(busy), 92'(1'b0));
      check("arst_out_valid", 92'(out_valid), 92'(1'b0));
      check("arst_in_ready",  92'(in_ready), 92'(1'b1));
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      send({23'd4, 23'd3, 23'd2, 23'd1}, {4{23'd1}}, 1'b1,
           {23'd0, 23'd8380413, 23'd8380415, 23'd10}, 1);
      drain(100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
